// File: rtl/act_skew_feeder_pkg.sv
// Shared defaults, FSM encoding and lane-slicing helper for the activation skew feeder.
package act_skew_feeder_pkg;

  localparam int P_ACT_BW      = 8;
  localparam int P_NUM_PE_ROWS = 8;
  localparam int P_MATRIX_SIZE = 8;
  localparam int P_WORDSIZE    = P_ACT_BW * P_NUM_PE_ROWS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Low bit of byte lane `lane` inside a packed activation word.
  function automatic int lane_lo(input int lane, input int bw);
    return lane * bw;
  endfunction

endpackage

// File: rtl/act_skew_feeder_skew_line.sv
// skew_line: DEPTH+1 registered stages of {valid, data} for one lane; data is forced
// to zero whenever the entering slot is invalid, so bubbles travel as clean zeros.
module act_skew_feeder_skew_line #(
  parameter int DEPTH  = 0,
  parameter int ACT_BW = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_valid,
  input  logic [ACT_BW-1:0] i_data,
  output logic              o_valid,
  output logic [ACT_BW-1:0] o_data
);

  logic [DEPTH:0]    r_vld;
  logic [ACT_BW-1:0] r_dat [DEPTH+1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld <= '0;
      for (int i = 0; i <= DEPTH; i++) r_dat[i] <= '0;
    end else begin
      r_vld[0] <= i_valid;
      r_dat[0] <= i_valid ? i_data : '0;
      for (int i = 1; i <= DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign o_valid = r_vld[DEPTH];
  assign o_data  = r_dat[DEPTH];

endmodule

// File: rtl/act_skew_feeder.sv
// Activation skew feeder: frames one tile of MATRIX_SIZE vectors and delays lane k by
// k cycles so the PE array sees a diagonal wavefront; pulses done after the drain.
module act_skew_feeder
  import act_skew_feeder_pkg::*;
#(
  parameter int ACT_BW      = P_ACT_BW,
  parameter int NUM_PE_ROWS = P_NUM_PE_ROWS,
  parameter int MATRIX_SIZE = P_MATRIX_SIZE,
  parameter int WORDSIZE    = ACT_BW * NUM_PE_ROWS
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [WORDSIZE-1:0]    in_data,
  output logic [WORDSIZE-1:0]    out_data,
  output logic [NUM_PE_ROWS-1:0] out_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output state_t                 dbg_state
);

  localparam int VEC_W = $clog2(MATRIX_SIZE + 1);
  localparam int DRN_W = $clog2(NUM_PE_ROWS + 1);

  state_t           r_state;
  logic [VEC_W-1:0] r_vec_cnt;
  logic [DRN_W-1:0] r_drain_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             w_accept;

  // Input handshake: there is no ready; in_valid is consumed only while in FEED.
  // A valid seen in IDLE (without start) or DRAIN is dropped and flagged in err.
  assign w_accept = (r_state == ST_FEED) && in_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_vec_cnt   <= '0;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // An accepted start wins over a coincident in_valid: the word is dropped, err cleared.
          if (start) begin
            r_state     <= ST_FEED;
            r_vec_cnt   <= '0;
            r_drain_cnt <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b1;
          end else if (in_valid) begin
            r_err <= 1'b1;
          end
        end
        ST_FEED: begin
          if (in_valid) begin
            r_vec_cnt <= r_vec_cnt + VEC_W'(1);
            if (r_vec_cnt == VEC_W'(MATRIX_SIZE - 1)) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (in_valid) r_err <= 1'b1;
          r_drain_cnt <= r_drain_cnt + DRN_W'(1);
          if (r_drain_cnt == DRN_W'(NUM_PE_ROWS - 1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

  for (genvar k = 0; k < NUM_PE_ROWS; k++) begin : g_lane
    act_skew_feeder_skew_line #(
      .DEPTH  (k),
      .ACT_BW (ACT_BW)
    ) u_line (
      .clk     (clk),
      .rstn    (rstn),
      .i_valid (w_accept),
      .i_data  (in_data[lane_lo(k, ACT_BW) +: ACT_BW]),
      .o_valid (out_valid[k]),
      .o_data  (out_data[lane_lo(k, ACT_BW) +: ACT_BW])
    );
  end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Bench for act_skew_feeder: timestamp-based tile model plus per-cycle lane lookup of
// accepted vectors, compared every negedge, with literal spot checks in directed tests.
module tb_act_skew_feeder;
  import act_skew_feeder_pkg::*;

  localparam int W    = P_WORDSIZE;
  localparam int NR   = P_NUM_PE_ROWS;
  localparam int BW   = P_ACT_BW;
  localparam int MS   = P_MATRIX_SIZE;
  localparam int MAXC = 8192;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic [W-1:0]  out_data;
  logic [NR-1:0] out_valid;
  logic          busy;
  logic          done;
  logic          err;
  state_t        dbg_state;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  act_skew_feeder dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Accepted vectors indexed by the cycle they were taken; lane k shows them k+1 cycles later.
  bit           acc_v [MAXC];
  logic [W-1:0] acc_d [MAXC];
  int           last_rst = -1;
  bit           tile_seen = 1'b0;
  int           t_start = 0;
  int           t_last = -1000;
  int           n_acc = 0;
  bit           m_err = 1'b0;

  int            t, c_idx;
  bit            m_fe, m_bz, m_dn;
  logic [W-1:0]  e_d;
  logic [NR-1:0] e_v;
  state_t        e_st;

  always @(negedge clk) begin
    t = cyc;
    if (!rstn) begin
      chk("rst_data", out_data, '0);
      chk("rst_valid", W'(out_valid), '0);
      chk("rst_busy", W'(busy), '0);
      chk("rst_done", W'(done), '0);
      chk("rst_err", W'(err), '0);
      chk("rst_state", W'(dbg_state), W'(ST_IDLE));
      tile_seen = 1'b0;
      n_acc     = 0;
      t_last    = -1000;
      m_err     = 1'b0;
      last_rst  = t;
    end else begin
      e_d = '0;
      e_v = '0;
      for (int k = 0; k < NR; k++) begin
        c_idx = t - 1 - k;
        if (c_idx > last_rst && c_idx >= 0 && c_idx < MAXC && acc_v[c_idx]) begin
          e_v[k] = 1'b1;
          e_d[k*BW +: BW] = acc_d[c_idx][k*BW +: BW];
        end
      end
      m_fe = tile_seen && (t > t_start) && (n_acc < MS);
      m_bz = tile_seen && (t > t_start) && ((n_acc < MS) || (t <= t_last + NR));
      m_dn = tile_seen && (n_acc == MS) && (t == t_last + NR + 1);
      e_st = m_fe ? ST_FEED : (m_bz ? ST_DRAIN : ST_IDLE);
      chk("data", out_data, e_d);
      chk("valid", W'(out_valid), W'(e_v));
      chk("busy", W'(busy), W'(m_bz));
      chk("done", W'(done), W'(m_dn));
      chk("err", W'(err), W'(m_err));
      chk("state", W'(dbg_state), W'(e_st));
      // Advance the model with this cycle's inputs.
      if (!m_bz && start) begin
        tile_seen = 1'b1;
        t_start   = t;
        n_acc     = 0;
        t_last    = -1000;
        m_err     = 1'b0;
      end else if (m_fe && in_valid) begin
        if (t < MAXC) begin
          acc_v[t] = 1'b1;
          acc_d[t] = in_data;
        end
        n_acc++;
        if (n_acc == MS) t_last = t;
      end else if (in_valid) begin
        m_err = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [W-1:0] d, input bit s);
    tick();
    in_valid = v;
    in_data  = d;
    start    = s;
  endtask

  task automatic at_neg(input int target);
    while (cyc < target) begin
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      start    = 1'b0;
    end
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rnd_word();
    return {$urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  logic [W-1:0] base_w, a_w, b_w, first_w;
  int n, m, na, got, extra;
  bit v;

  initial begin
    base_w = 64'h0807060504030201;
    a_w    = 64'h1122334455667788;
    b_w    = 64'h99AABBCCDDEEFF00;

    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    at_neg(cyc + 1);
    chk("idle_busy", W'(busy), '0);

    // Basic tile followed by a back-to-back tile started in the done cycle.
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < MS; i++) begin
      drive(1'b1, base_w + W'(i), 1'b0);
      if (i == 0) n = cyc;
      if (i > 0) begin
        @(negedge clk);
        chk("basic_lane0", W'(out_data[7:0]), W'(i));
      end
    end
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("basic_lane0_last", W'(out_data[7:0]), W'(8'h08));
    chk("basic_lane7_first", W'(out_data[63:56]), W'(8'h08));
    chk("basic_all_valid", W'(out_valid), W'(8'hFF));
    at_neg(n + 15);
    chk("basic_lane7_tail_valid", W'(out_valid), W'(8'h80));
    chk("basic_lane7_tail", W'(out_data[63:56]), W'(8'h08));
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    chk("basic_done_cyc", W'(cyc), W'(n + 16));
    chk("basic_done", W'(done), W'(1'b1));
    chk("basic_busy_in_done", W'(busy), '0);
    for (int i = 0; i < MS; i++) begin
      drive(1'b1, rnd_word(), 1'b0);
      if (i == 0) first_w = in_data;
      if (i == 1) begin
        @(negedge clk);
        chk("b2b_lane0_first", W'(out_data[7:0]), W'(first_w[7:0]));
        chk("b2b_valid0", W'(out_valid[0]), W'(1'b1));
      end
    end
    at_neg(cyc + 12);

    // Bubble between A and B.
    drive(1'b0, '0, 1'b1);
    drive(1'b1, a_w, 1'b0);
    na = cyc;
    drive(1'b0, '0, 1'b0);
    drive(1'b1, b_w, 1'b0);
    for (int i = 0; i < MS - 2; i++) drive(1'b1, rnd_word(), 1'b0);
    at_neg(na + 8);
    chk("bubble_lane7_a", W'(out_data[63:56]), W'(8'h11));
    at_neg(na + 9);
    chk("bubble_lane7_gap_v", W'(out_valid[7]), '0);
    chk("bubble_lane7_gap_d", W'(out_data[63:56]), '0);
    at_neg(na + 10);
    chk("bubble_lane7_b", W'(out_data[63:56]), W'(8'h99));
    at_neg(cyc + 6);

    // Illegal valid in IDLE; err sticks.
    drive(1'b1, '1, 1'b0);
    n = cyc;
    at_neg(n + 1);
    chk("illegal_err", W'(err), W'(1'b1));
    chk("illegal_no_valid", W'(out_valid), '0);
    at_neg(n + 3);
    chk("illegal_err_held", W'(err), W'(1'b1));

    // start+valid in IDLE (word dropped), start poke in FEED, illegal valid in DRAIN.
    drive(1'b1, rnd_word(), 1'b1);
    for (int i = 0; i < MS; i++) begin
      drive(1'b1, rnd_word(), i == 3);
      if (i == 0) begin
        @(negedge clk);
        chk("start_clears_err", W'(err), '0);
      end
    end
    m = cyc;
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    drive(1'b1, '1, 1'b0);
    at_neg(m + 5);
    chk("drain_err", W'(err), W'(1'b1));
    at_neg(m + 8);
    chk("coll_not_done_yet", W'(done), '0);
    chk("coll_busy", W'(busy), W'(1'b1));
    at_neg(m + 9);
    chk("coll_done", W'(done), W'(1'b1));
    at_neg(cyc + 3);

    // Reset two cycles after the third vector of a tile.
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, rnd_word(), 1'b0);
    drive(1'b0, '0, 1'b0);
    tick();
    rstn = 1'b0;
    #1;
    chk("midrst_data", out_data, '0);
    chk("midrst_valid", W'(out_valid), '0);
    chk("midrst_busy", W'(busy), '0);
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, '0, 1'b0);
      @(negedge clk);
      chk("midrst_no_done", W'(done), '0);
    end

    // Randomized tiles with gaps, start pokes and illegal valids outside FEED.
    repeat (20) begin
      drive(1'b0, '0, 1'b1);
      got = 0;
      while (got < MS) begin
        v = ($urandom_range(0, 99) < 70);
        drive(v, rnd_word(), $urandom_range(0, 9) == 0);
        if (v) got++;
      end
      extra = NR + $urandom_range(1, 4);
      for (int i = 0; i < extra; i++) drive($urandom_range(0, 9) == 0, rnd_word(), 1'b0);
    end
    at_neg(cyc + 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
